// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy risk front-end: sequencer states,
// error codes reported to the host and the fail-safe risk value.
package fuzzy_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Reported when the engine never answers: assume the worst case.
    localparam logic [7:0] RISK_FAILSAFE = 8'hFF;

endpackage

// File: rtl/frame_deser.sv
// Frame deserializer: detects the ss rising edge, counts bytes and fills the
// input register bank. Capture is only enabled while the sequencer says so
// (i_arm in IDLE, i_load in LOAD), which keeps the bank frozen otherwise.
module frame_deser
    import fuzzy_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DW         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_ss,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_arm,
    input  logic                     i_load,
    output logic                     o_frame_start,
    output logic                     o_frame_done,
    output logic                     o_frame_short,
    output logic [NUM_INPUTS*DW-1:0] o_bank
);

    localparam int CW = $clog2(NUM_INPUTS + 1);

    logic            r_ss_q;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_bank [NUM_INPUTS];
    logic            w_rise;
    logic            w_last;

    assign w_rise        = i_ss & ~r_ss_q;
    assign w_last        = (r_cnt == CW'(NUM_INPUTS - 1));
    assign o_frame_start = i_arm & w_rise;
    // A one-byte frame completes on the very edge that opens it.
    assign o_frame_done  = (o_frame_start & (NUM_INPUTS == 1)) | (i_load & i_ss & w_last);
    assign o_frame_short = i_load & ~i_ss;

    // Edge-detect register, byte counter and input bank capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_q <= 1'b0;
            r_cnt  <= '0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            r_ss_q <= i_ss;
            if (o_frame_start) begin
                r_bank[0] <= i_data;
                r_cnt     <= CW'(1);
            end else if (i_load && i_ss) begin
                for (int k = 1; k < NUM_INPUTS; k++) begin
                    if (r_cnt == CW'(k)) begin
                        r_bank[k] <= i_data;
                    end
                end
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pack
        assign o_bank[g*DW +: DW] = r_bank[g];
    end

endmodule

// File: rtl/fuzzy_frame_ctrl.sv
// Sequencer between the byte-wide host port and the fuzzy inference engine:
// deframes an ss burst, pulses the engine start, then latches the engine
// result (or a fail-safe value on timeout) onto the risk output.
module fuzzy_frame_ctrl
    import fuzzy_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DW         = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ss,
    input  logic [DW-1:0]            data_bus,
    output logic [NUM_INPUTS*DW-1:0] eng_in,
    output logic                     eng_start,
    input  logic                     eng_done,
    input  logic [DW-1:0]            eng_risk,
    output logic [DW-1:0]            risk,
    output logic                     risk_valid,
    output logic                     busy,
    output logic [1:0]               err
);

    localparam int TW = 8;

    state_t          r_state;
    logic            r_eng_start;
    logic [DW-1:0]   r_risk;
    logic            r_risk_valid;
    logic            r_busy;
    logic [1:0]      r_err;
    logic [TW-1:0]   r_timer;

    logic            w_frame_start;
    logic            w_frame_done;
    logic            w_frame_short;

    frame_deser #(
        .NUM_INPUTS (NUM_INPUTS),
        .DW         (DW)
    ) u_deser (
        .clk           (clk),
        .rst           (rst),
        .i_ss          (ss),
        .i_data        (data_bus),
        .i_arm         (r_state == IDLE),
        .i_load        (r_state == LOAD),
        .o_frame_start (w_frame_start),
        .o_frame_done  (w_frame_done),
        .o_frame_short (w_frame_short),
        .o_bank        (eng_in)
    );

    // Frame sequencer with registered start pulse, busy flag, timer and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_eng_start  <= 1'b0;
            r_risk       <= '0;
            r_risk_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= ERR_OK;
            r_timer      <= '0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_frame_start) begin
                        r_busy <= 1'b1;
                        if (w_frame_done) begin
                            r_eng_start <= 1'b1;
                            r_state     <= START;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_frame_short) begin
                        r_err   <= ERR_SHORT;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_frame_done) begin
                        r_eng_start <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // eng_done is checked first so it wins over a same-cycle timeout.
                    if (eng_done) begin
                        r_risk       <= eng_risk;
                        r_risk_valid <= 1'b1;
                        r_err        <= ERR_OK;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end else if (r_timer == TW'(TIMEOUT - 2)) begin
                        r_risk       <= DW'(RISK_FAILSAFE);
                        r_risk_valid <= 1'b1;
                        r_err        <= ERR_TIMEOUT;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                DONE: begin
                    // Holding ss high here swallows trailing bytes; a new frame needs ss low first.
                    if (!ss) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign eng_start  = r_eng_start;
    assign risk       = r_risk;
    assign risk_valid = r_risk_valid;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_fuzzy_frame_ctrl.sv
// Scoreboard bench for fuzzy_frame_ctrl: stimulus pushes expected engine
// starts and frame outcomes; a monitor pops and compares them whenever the
// DUT pulses eng_start or drops busy.
module tb_fuzzy_frame_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            ss;
    logic [DW-1:0]   data_bus;
    logic [N*DW-1:0] eng_in;
    logic            eng_start;
    logic            eng_done;
    logic [DW-1:0]   eng_risk;
    logic [DW-1:0]   risk;
    logic            risk_valid;
    logic            busy;
    logic [1:0]      err;

    fuzzy_frame_ctrl #(.NUM_INPUTS(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .data_bus   (data_bus),
        .eng_in     (eng_in),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_risk   (eng_risk),
        .risk       (risk),
        .risk_valid (risk_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N*DW-1:0] ein;
        int              cyc;
    } start_t;

    typedef struct {
        logic [7:0] risk;
        logic       valid;
        logic [1:0] err;
        int         cyc;
    } res_t;

    start_t     q_start[$];
    res_t       q_res[$];

    // Reference model: what risk/risk_valid currently hold.
    logic [7:0] m_risk;
    logic       m_valid;

    // Engine behaviour for the next start: delay in cycles (0 = never answers).
    int         eng_d;
    logic [7:0] eng_v;
    bit         eng_active;

    logic [7:0] fb [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset();
        chk("rst_eng_in", 64'(eng_in), 64'(0));
        chk("rst_eng_start", 64'(eng_start), 64'(0));
        chk("rst_risk", 64'(risk), 64'(0));
        chk("rst_risk_valid", 64'(risk_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
    endtask

    // Called in the "just after posedge" phase; holds rst across two edges.
    task automatic do_reset();
        rst = 1'b1;
        ss  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_risk  = 8'h00;
        m_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        ss       = 1'b0;
        data_bus = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [N*DW-1:0] packed_frame();
        logic [N*DW-1:0] p;
        for (int k = 0; k < N; k++) p[k*DW +: DW] = fb[k];
        return p;
    endfunction

    // Holds ss high for nbytes cycles presenting fb[]; a frame of at least N
    // bytes starts the engine, fewer is a short frame.
    task automatic send_frame(input int nbytes, input int d, input logic [7:0] rv, input bit push_res);
        res_t r;
        eng_d = d;
        eng_v = rv;
        for (int i = 0; i < nbytes; i++) begin
            ss       = 1'b1;
            data_bus = fb[i];
            if (i == N - 1) begin
                q_start.push_back('{packed_frame(), cyc + 1});
                if (push_res) begin
                    if (d >= 1 && d <= TO - 1) begin
                        m_risk = rv;
                        r      = '{rv, 1'b1, 2'b00, cyc + 2 + d};
                    end else begin
                        m_risk = 8'hFF;
                        r      = '{8'hFF, 1'b1, 2'b10, cyc + 1 + TO};
                    end
                    m_valid = 1'b1;
                    q_res.push_back(r);
                end
            end
            @(posedge clk);
            #1;
        end
        ss       = 1'b0;
        data_bus = 8'($urandom);
        if (nbytes < N && push_res) begin
            q_res.push_back('{m_risk, m_valid, 2'b01, cyc + 1});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_res.size() != 0 || q_start.size() != 0 || eng_active) && n < 6 * TO + 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q_res.size() != 0 || q_start.size() != 0 || eng_active) begin
            checks++;
            errors++;
            $display("FAIL frame_complete: got %0d starts and %0d results still pending, expected 0", q_start.size(), q_res.size());
            q_res.delete();
            q_start.delete();
        end
    endtask

    task automatic rand_fb();
        for (int k = 0; k < 16; k++) fb[k] = 8'($urandom);
    endtask

    // Monitor: compares every DUT start pulse and every end of a busy period.
    initial begin
        start_t s;
        res_t   r;
        logic   pb;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                if (q_start.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got eng_start=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    s = q_start.pop_front();
                    chk("eng_in", 64'(eng_in), 64'(s.ein));
                    chk("start_cycle", 64'(cyc), 64'(s.cyc));
                end
            end
            if (pb && busy === 1'b0 && rst === 1'b0) begin
                if (q_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got busy fall, expected none (cycle %0d)", cyc);
                end else begin
                    r = q_res.pop_front();
                    chk("risk", 64'(risk), 64'(r.risk));
                    chk("risk_valid", 64'(risk_valid), 64'(r.valid));
                    chk("err", 64'(err), 64'(r.err));
                    chk("result_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            pb = busy;
        end
    end

    // Engine model: answers each start after eng_d cycles (or never).
    initial begin
        int         dd;
        logic [7:0] v;
        eng_done   = 1'b0;
        eng_risk   = 8'h00;
        eng_active = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1 && eng_d > 0) begin
                eng_active = 1'b1;
                dd         = eng_d;
                v          = eng_v;
                repeat (dd) @(posedge clk);
                #1;
                eng_done = 1'b1;
                eng_risk = v;
                @(posedge clk);
                #1;
                eng_done   = 1'b0;
                eng_risk   = 8'($urandom);
                eng_active = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rv;
        int         kind;
        int         nb;
        int         dsel;
        int         d;

        rst      = 1'b1;
        ss       = 1'b0;
        data_bus = 8'h00;
        eng_d    = 0;
        eng_v    = 8'h00;
        do_reset();

        // Nominal frame, ss held past the result so DONE must hold.
        rand_fb();
        fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'h30; fb[3] = 8'h40;
        send_frame(10, 3, 8'h5A, 1'b1);
        wait_idle();
        chk("eng_in_hold", 64'(eng_in), 64'h40302010);
        gap(2);

        // Short frame keeps the previous risk.
        fb[0] = 8'hAA; fb[1] = 8'hBB;
        send_frame(2, 0, 8'h00, 1'b1);
        wait_idle();
        gap(2);

        // Next full frame accepted normally.
        rand_fb();
        send_frame(N, 2, 8'h33, 1'b1);
        wait_idle();
        gap(1);

        // Engine times out, then answers late.
        rand_fb();
        send_frame(N, TO + 3, 8'h12, 1'b1);
        wait_idle();
        chk("late_done_risk", 64'(risk), 64'hFF);
        chk("late_done_err", 64'(err), 64'h2);
        gap(1);

        // Done on the last permitted cycle wins; one later is a timeout.
        rand_fb();
        send_frame(N, TO - 1, 8'h77, 1'b1);
        wait_idle();
        gap(1);
        rand_fb();
        send_frame(N, TO, 8'h66, 1'b1);
        wait_idle();
        gap(1);

        // ss high 7 cycles: one start, trailing bytes ignored.
        rand_fb();
        send_frame(7, 1, 8'h3C, 1'b1);
        wait_idle();
        chk("eng_in_extra", 64'(eng_in), 64'(packed_frame()));
        gap(2);

        // Reset in LOAD after two bytes.
        rand_fb();
        ss = 1'b1; data_bus = fb[0];
        @(posedge clk); #1;
        data_bus = fb[1];
        @(posedge clk); #1;
        do_reset();
        gap(3);
        chk("load_rst_valid", 64'(risk_valid), 64'(0));

        // Establish a result, then reset in WAIT; the late done must be ignored.
        rand_fb();
        send_frame(N, 2, 8'h9C, 1'b1);
        wait_idle();
        gap(1);
        rand_fb();
        send_frame(N, 6, 8'h44, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset();
        wait_idle();
        gap(2);
        chk("wait_rst_valid", 64'(risk_valid), 64'(0));
        chk("wait_rst_risk", 64'(risk), 64'(0));
        chk("wait_rst_busy", 64'(busy), 64'(0));
        chk("wait_rst_err", 64'(err), 64'(0));

        // Randomized frames.
        for (int it = 0; it < 30; it++) begin
            rand_fb();
            kind = $urandom_range(0, 3);
            if (kind == 0) nb = $urandom_range(1, N - 1);
            else           nb = N + $urandom_range(0, 3);
            dsel = $urandom_range(0, 9);
            if (dsel == 0)      d = 0;
            else if (dsel == 1) d = TO - 1;
            else if (dsel == 2) d = TO;
            else                d = $urandom_range(1, 6);
            rv = 8'($urandom);
            send_frame(nb, d, rv, 1'b1);
            wait_idle();
            gap($urandom_range(1, 3));
        end

        chk("start_queue_empty", 64'(q_start.size()), 64'(0));
        chk("result_queue_empty", 64'(q_res.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
